ttni_source_fsm: RTL and testbench
==================================

Name: ttni_source_fsm

Overview:
- Transmit-side counterpart of the TTNI gateway sink. Reads a message from the local message buffer and injects it into the NoC as one packet on virtual channel 0.
- Packet layout, in order:
  - header flit carrying the destination port id;
  - timestamp flit carrying the injection time from the global time base (GTB);
  - 0..MAX_MSG_LEN payload flits.
- Sits between the gateway control/status registers (start, destination, length) and the router local input port.

Parameters:
- VCHANNELS, 1, number of virtual channels; only VC0 is driven.
- FLIT_DATA_WIDTH, 32, flit payload width.
- FLIT_TYPE_WIDTH, 2, flit type field width.
- FLIT_WIDTH, FLIT_DATA_WIDTH+FLIT_TYPE_WIDTH, total flit width.
- MAX_MSG_LEN, 1024, maximum payload words per packet.
- ADDR_WIDTH, 12, message buffer address width.
- BASE_ADDR, 40, buffer address of payload word 0.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_source_n  in  1  synchronous active-low reset.
- tx_start  in  1  request to send one packet; sampled only in IDLE.
- tx_dest  in  5  destination port id.
- tx_len  in  16  payload word count.
- GTB  in  64  global time base.
- mem_rd_en  out  1  buffer read strobe.
- mem_rd_addr  out  ADDR_WIDTH  buffer read address.
- mem_rd_data  in  FLIT_DATA_WIDTH  read data, valid the cycle after mem_rd_en.
- flit  out  FLIT_WIDTH  outgoing flit as {type, data}.
- valid  out  VCHANNELS  flit valid; bit 0 only, other bits 0.
- ready  in  VCHANNELS  router ready; bit 0 used.
- tx_busy  out  1  high while a packet is in progress.
- tx_done  out  1  one-cycle pulse after the last flit is accepted.
- tx_count  out  32  packets completed since reset, wraps at 2^32.

Behaviour:
- One clock domain. Reset is synchronous and active-low: rst_source_n low at a clk posedge resets every register.
- Reset values:
  - state = IDLE;
  - flit = 0, valid = 0;
  - mem_rd_en = 0, mem_rd_addr = 0;
  - tx_busy = 0, tx_done = 0, tx_count = 0.
- All outputs are registered.
- Flit types:
  - 2'b01 header;
  - 2'b00 payload or timestamp;
  - 2'b10 last.
- Handshake:
  - a flit transfers on a posedge where valid[0] and ready[0] are both 1;
  - while valid[0]=1 and ready[0]=0, flit and valid stay stable;
  - valid never drops without a transfer, except on reset.
- States:
  - IDLE: on tx_start=1, latch dest=tx_dest, len=min(tx_len, MAX_MSG_LEN) and ts=GTB[31:0]. Drive flit={01, 27'b0, tx_dest}, valid=1, go to HDR. The header is valid in the cycle after tx_start.
  - HDR: on transfer, drive flit={len==0 ? 10 : 00, ts}, go to TS.
  - TS: on transfer, if len==0 go to DONE with valid=0. Otherwise set valid=0, mem_rd_en=1, mem_rd_addr=BASE_ADDR, idx=0, go to RD.
  - RD: mem_rd_en=0, go to WAIT.
  - WAIT: capture flit={idx==len-1 ? 10 : 00, mem_rd_data}, valid=1, go to PAY.
  - PAY: on transfer, if the last flit was sent go to DONE with valid=0. Otherwise idx+1, mem_rd_en=1, mem_rd_addr=BASE_ADDR+idx+1, go to RD.
  - DONE: tx_done=1 for this one cycle, tx_count+1, go to IDLE.
- Payload timing: a payload flit becomes valid 2 cycles after its mem_rd_en. With ready held high, consecutive payload flits are 3 cycles apart.
- tx_busy = 1 in every state except IDLE.
- tx_start while busy is ignored; it is not queued.
- tx_len > MAX_MSG_LEN is clamped to MAX_MSG_LEN.
- mem_rd_addr arithmetic is modulo 2^ADDR_WIDTH.
- Reset mid-packet: the next cycle has valid=0 and state=IDLE, and no tx_done is issued. The truncated packet is accepted behaviour.
- tx_done and a new tx_start never overlap: the start is sampled only in IDLE, one cycle after DONE.

Test Plan:
- Basic packet. Stimulus: reset, tx_dest=5, tx_len=3, GTB=0x0000_0000_1234_5678, ready=1, buffer[40..42]=0xA0..0xA2. Required flit sequence:
  - 34'h1_0000_0005;
  - 34'h0_1234_5678;
  - 34'h0_0000_00A0;
  - 34'h0_0000_00A1;
  - 34'h2_0000_00A2.
  - Then tx_done pulses once and tx_count=1.
- Zero length. Stimulus: tx_len=0, GTB low word 0xDEADBEEF. Required: exactly two flits, 34'h1_0000_00xx (header) then 34'h2_DEAD_BEEF; no mem_rd_en; tx_done.
- Backpressure. Stimulus: ready low for 4 cycles on the timestamp flit and again on payload flit 1. Required: flit/valid stable throughout each stall; no duplicated or lost words; mem_rd_en count equals tx_len.
- Busy and clamp. Stimulus: tx_start pulsed during a packet, then tx_len=2000. Required: the mid-packet start is ignored; the second packet carries 1024 payload flits and its last read address is 40+1023.
- Reset mid-packet. Stimulus: rst_source_n low for 1 cycle during payload flit 2. Required: next cycle valid=0, tx_busy=0, tx_count unchanged from reset (0), no tx_done.
- Counter. Stimulus: 5 back-to-back packets with tx_len=1. Required: tx_count=5 and 5 tx_done pulses, each 1 cycle wide.

Source files
------------

// File: rtl/ttni_source_fsm_if.sv
// Router local-port link plus message-buffer read port for the TTNI source.
// The master side is the packet source; the slave side is router plus buffer.
interface ttni_source_fsm_if #(
  parameter int VCHANNELS       = 1,
  parameter int FLIT_DATA_WIDTH = 32,
  parameter int FLIT_WIDTH      = 34,
  parameter int ADDR_WIDTH      = 12
);
  logic [FLIT_WIDTH-1:0]      flit;
  logic [VCHANNELS-1:0]       valid;
  logic [VCHANNELS-1:0]       ready;
  logic                       mem_rd_en;
  logic [ADDR_WIDTH-1:0]      mem_rd_addr;
  logic [FLIT_DATA_WIDTH-1:0] mem_rd_data;

  modport master (
    output flit, valid, mem_rd_en, mem_rd_addr,
    input  ready, mem_rd_data
  );

  modport slave (
    input  flit, valid, mem_rd_en, mem_rd_addr,
    output ready, mem_rd_data
  );
endinterface

// File: rtl/ttni_source_fsm.sv
// TTNI gateway source: reads a message from the local buffer and injects it
// on VC0 as one packet (header, GTB timestamp, 0..MAX_MSG_LEN payload flits).
module ttni_source_fsm #(
  parameter int VCHANNELS       = 1,
  parameter int FLIT_DATA_WIDTH = 32,
  parameter int FLIT_TYPE_WIDTH = 2,
  parameter int FLIT_WIDTH      = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH,
  parameter int MAX_MSG_LEN     = 1024,
  parameter int ADDR_WIDTH      = 12,
  parameter int BASE_ADDR       = 40
) (
  input  logic                 clk,
  input  logic                 rst_source_n,
  input  logic                 tx_start,
  input  logic [4:0]           tx_dest,
  input  logic [15:0]          tx_len,
  input  logic [63:0]          GTB,
  ttni_source_fsm_if.master    bus,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic [31:0]          tx_count
);

  localparam int LEN_W = $clog2(MAX_MSG_LEN + 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] HDR  = 3'd1;
  localparam logic [2:0] TS   = 3'd2;
  localparam logic [2:0] RD   = 3'd3;
  localparam logic [2:0] WAIT = 3'd4;
  localparam logic [2:0] PAY  = 3'd5;
  localparam logic [2:0] DONE = 3'd6;

  localparam logic [FLIT_TYPE_WIDTH-1:0] FT_HDR  = FLIT_TYPE_WIDTH'(1);
  localparam logic [FLIT_TYPE_WIDTH-1:0] FT_PAY  = FLIT_TYPE_WIDTH'(0);
  localparam logic [FLIT_TYPE_WIDTH-1:0] FT_LAST = FLIT_TYPE_WIDTH'(2);

  logic [2:0]       state_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] idx_r;
  logic [31:0]      ts_r;
  logic             last_r;
  logic [LEN_W-1:0] len_clamp_s;
  logic             xfer_s;
  logic             unused_gtb_s;

  function automatic logic [FLIT_WIDTH-1:0] make_flit(
    input logic [FLIT_TYPE_WIDTH-1:0] ftype,
    input logic [FLIT_DATA_WIDTH-1:0] data
  );
    return {ftype, data};
  endfunction

  // Only the low GTB word is carried in the timestamp flit.
  assign unused_gtb_s = ^GTB[63:32];
  assign xfer_s       = bus.valid[0] & bus.ready[0];

  // Oversized requests are truncated to the largest packet we can send.
  always_comb begin
    len_clamp_s = LEN_W'(0);
    if (tx_len > 16'(MAX_MSG_LEN)) begin
      len_clamp_s = LEN_W'(MAX_MSG_LEN);
    end else begin
      len_clamp_s = tx_len[LEN_W-1:0];
    end
  end

  // Packet sequencer: all outputs are driven from here as registers.
  always_ff @(posedge clk) begin
    if (!rst_source_n) begin
      state_r         <= IDLE;
      len_r           <= LEN_W'(0);
      idx_r           <= LEN_W'(0);
      ts_r            <= 32'd0;
      last_r          <= 1'b0;
      bus.flit        <= FLIT_WIDTH'(0);
      bus.valid       <= VCHANNELS'(0);
      bus.mem_rd_en   <= 1'b0;
      bus.mem_rd_addr <= ADDR_WIDTH'(0);
      tx_busy         <= 1'b0;
      tx_done         <= 1'b0;
      tx_count        <= 32'd0;
    end else begin
      tx_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (tx_start) begin
            len_r     <= len_clamp_s;
            ts_r      <= GTB[31:0];
            bus.flit  <= make_flit(FT_HDR, FLIT_DATA_WIDTH'(tx_dest));
            bus.valid <= VCHANNELS'(1);
            tx_busy   <= 1'b1;
            state_r   <= HDR;
          end
        end
        HDR: begin
          if (xfer_s) begin
            bus.flit <= make_flit((len_r == LEN_W'(0)) ? FT_LAST : FT_PAY, ts_r);
            state_r  <= TS;
          end
        end
        TS: begin
          if (xfer_s) begin
            bus.valid <= VCHANNELS'(0);
            if (len_r == LEN_W'(0)) begin
              state_r <= DONE;
            end else begin
              bus.mem_rd_en   <= 1'b1;
              bus.mem_rd_addr <= ADDR_WIDTH'(BASE_ADDR);
              idx_r           <= LEN_W'(0);
              state_r         <= RD;
            end
          end
        end
        RD: begin
          bus.mem_rd_en <= 1'b0;
          state_r       <= WAIT;
        end
        WAIT: begin
          last_r    <= (idx_r == len_r - LEN_W'(1));
          bus.flit  <= make_flit((idx_r == len_r - LEN_W'(1)) ? FT_LAST : FT_PAY,
                                 bus.mem_rd_data);
          bus.valid <= VCHANNELS'(1);
          state_r   <= PAY;
        end
        PAY: begin
          if (xfer_s) begin
            bus.valid <= VCHANNELS'(0);
            if (last_r) begin
              state_r <= DONE;
            end else begin
              idx_r           <= idx_r + LEN_W'(1);
              bus.mem_rd_en   <= 1'b1;
              bus.mem_rd_addr <= bus.mem_rd_addr + ADDR_WIDTH'(1);
              state_r         <= RD;
            end
          end
        end
        DONE: begin
          tx_done  <= 1'b1;
          tx_count <= tx_count + 32'd1;
          tx_busy  <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          bus.valid     <= VCHANNELS'(0);
          bus.mem_rd_en <= 1'b0;
          tx_busy       <= 1'b0;
          state_r       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ttni_source_fsm.sv
// Directed self-checking bench for ttni_source_fsm: a posedge monitor logs
// transfers/reads/done pulses, and per-scenario tasks compare against constants.
module tb_ttni_source_fsm;

  logic        clk = 1'b0;
  logic        rst_source_n;
  logic        tx_start;
  logic [4:0]  tx_dest;
  logic [15:0] tx_len;
  logic [63:0] GTB;
  logic        tx_busy;
  logic        tx_done;
  logic [31:0] tx_count;

  always #5 clk = ~clk;

  ttni_source_fsm_if #(.VCHANNELS(1), .FLIT_DATA_WIDTH(32), .FLIT_WIDTH(34), .ADDR_WIDTH(12)) bus ();

  ttni_source_fsm dut (
    .clk          (clk),
    .rst_source_n (rst_source_n),
    .tx_start     (tx_start),
    .tx_dest      (tx_dest),
    .tx_len       (tx_len),
    .GTB          (GTB),
    .bus          (bus),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .tx_count     (tx_count)
  );

  logic [31:0] mem [0:4095];
  int errors = 0;
  int checks = 0;

  logic [33:0] flit_q [$];
  int          time_q [$];
  int          rd_en_cnt = 0;
  int          done_cnt = 0;
  int          done_wide = 0;
  int          stall_viol = 0;
  int          cyc = 0;
  logic [11:0] last_addr = 12'd0;
  logic        hold = 1'b0;
  logic        prev_done = 1'b0;
  logic [33:0] held = 34'd0;

  // Buffer model: registered read, data valid the cycle after mem_rd_en.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (hold && (bus.valid[0] !== 1'b1 || bus.flit !== held)) stall_viol++;
      hold = bus.valid[0] && !bus.ready[0] && rst_source_n;
      held = bus.flit;
      if (bus.valid[0] && bus.ready[0] && rst_source_n) begin
        flit_q.push_back(bus.flit);
        time_q.push_back(cyc);
      end
      if (bus.mem_rd_en) begin
        rd_en_cnt++;
        last_addr = bus.mem_rd_addr;
      end
      if (tx_done) begin
        done_cnt++;
        if (prev_done) done_wide++;
      end
      prev_done = tx_done;
    end
  end

  task automatic clear_mon();
    flit_q.delete();
    time_q.delete();
    rd_en_cnt  = 0;
    done_cnt   = 0;
    done_wide  = 0;
    stall_viol = 0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_source_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_source_n = 1'b1;
  endtask

  task automatic send(input logic [4:0] dest, input logic [15:0] len, input logic [63:0] gtb);
    logic [33:0] exp_hdr;
    exp_hdr = {2'b01, 27'd0, dest};
    @(negedge clk);
    tx_dest  = dest;
    tx_len   = len;
    GTB      = gtb;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    checks++;
    if (bus.valid !== 1'b1 || bus.flit !== exp_hdr) begin
      errors++;
      $display("FAIL header: got flit=%h valid=%b, expected flit=%h valid=1", bus.flit, bus.valid, exp_hdr);
    end
  endtask

  task automatic wait_done(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done_cnt >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_dut();
    @(negedge clk);
    checks++;
    if (bus.valid !== 1'b0 || bus.flit !== 34'd0) begin
      errors++;
      $display("FAIL reset_flit: got flit=%h valid=%b, expected 0/0", bus.flit, bus.valid);
    end
    checks++;
    if (bus.mem_rd_en !== 1'b0 || bus.mem_rd_addr !== 12'd0) begin
      errors++;
      $display("FAIL reset_mem: got en=%b addr=%h, expected 0/0", bus.mem_rd_en, bus.mem_rd_addr);
    end
    checks++;
    if (tx_busy !== 1'b0 || tx_done !== 1'b0 || tx_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_status: got busy=%b done=%b count=%0d, expected 0/0/0", tx_busy, tx_done, tx_count);
    end
  endtask

  task automatic test_basic();
    bit ok;
    logic [33:0] exp [5];
    exp[0] = 34'h1_0000_0005;
    exp[1] = 34'h0_1234_5678;
    exp[2] = 34'h0_0000_00A0;
    exp[3] = 34'h0_0000_00A1;
    exp[4] = 34'h2_0000_00A2;
    mem[40] = 32'hA0; mem[41] = 32'hA1; mem[42] = 32'hA2;
    clear_mon();
    send(5'd5, 16'd3, 64'h0000_0000_1234_5678);
    wait_done(1, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout: got done_cnt=%0d, expected 1", done_cnt); end
    checks++;
    if (flit_q.size() != 5) begin
      errors++;
      $display("FAIL basic_count: got %0d flits, expected 5", flit_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (flit_q[i] !== exp[i]) begin
          errors++;
          $display("FAIL basic_flit%0d: got %h, expected %h", i, flit_q[i], exp[i]);
        end
      end
      checks++;
      if (time_q[1] - time_q[0] != 1 || time_q[2] - time_q[1] != 3 ||
          time_q[3] - time_q[2] != 3 || time_q[4] - time_q[3] != 3) begin
        errors++;
        $display("FAIL basic_timing: got gaps %0d %0d %0d %0d, expected 1 3 3 3",
                 time_q[1] - time_q[0], time_q[2] - time_q[1], time_q[3] - time_q[2], time_q[4] - time_q[3]);
      end
    end
    checks++;
    if (tx_count !== 32'd1 || done_cnt != 1 || rd_en_cnt != 3 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_status: got count=%0d dones=%0d reads=%0d busy=%b, expected 1/1/3/0",
               tx_count, done_cnt, rd_en_cnt, tx_busy);
    end
  endtask

  task automatic test_zero_len();
    bit ok;
    clear_mon();
    send(5'd7, 16'd0, 64'h0000_0000_DEAD_BEEF);
    wait_done(1, 50, ok);
    checks++;
    if (!ok || flit_q.size() != 2) begin
      errors++;
      $display("FAIL zero_count: got %0d flits done=%0d, expected 2 flits 1 done", flit_q.size(), done_cnt);
    end else begin
      checks++;
      if (flit_q[0] !== 34'h1_0000_0007 || flit_q[1] !== 34'h2_DEAD_BEEF) begin
        errors++;
        $display("FAIL zero_flits: got %h %h, expected 100000007 2deadbeef", flit_q[0], flit_q[1]);
      end
    end
    checks++;
    if (rd_en_cnt != 0 || tx_count !== 32'd2) begin
      errors++;
      $display("FAIL zero_status: got reads=%0d count=%0d, expected 0/2", rd_en_cnt, tx_count);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit found;
    logic [33:0] exp [6];
    exp[0] = 34'h1_0000_0009;
    exp[1] = 34'h0_CAFE_0000;
    exp[2] = 34'h0_0000_00B0;
    exp[3] = 34'h0_0000_00B1;
    exp[4] = 34'h0_0000_00B2;
    exp[5] = 34'h2_0000_00B3;
    for (int i = 0; i < 4; i++) mem[40 + i] = 32'hB0 + 32'(i);
    clear_mon();
    send(5'd9, 16'd4, 64'h0000_0001_CAFE_0000);
    @(negedge clk);
    bus.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.valid !== 1'b1 || bus.flit !== exp[1]) begin
        errors++;
        $display("FAIL stall_ts: got flit=%h valid=%b, expected %h/1", bus.flit, bus.valid, exp[1]);
      end
    end
    bus.ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.valid[0] && bus.flit === exp[3]) begin found = 1'b1; break; end
    end
    bus.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (!found || bus.valid !== 1'b1 || bus.flit !== exp[3]) begin
        errors++;
        $display("FAIL stall_pay1: got flit=%h valid=%b, expected %h/1", bus.flit, bus.valid, exp[3]);
      end
    end
    bus.ready = 1'b1;
    wait_done(1, 100, ok);
    checks++;
    if (!ok || flit_q.size() != 6) begin
      errors++;
      $display("FAIL bp_count: got %0d flits done=%0d, expected 6 flits 1 done", flit_q.size(), done_cnt);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (flit_q[i] !== exp[i]) begin
          errors++;
          $display("FAIL bp_flit%0d: got %h, expected %h", i, flit_q[i], exp[i]);
        end
      end
    end
    checks++;
    if (stall_viol != 0 || rd_en_cnt != 4) begin
      errors++;
      $display("FAIL bp_status: got stall_violations=%0d reads=%0d, expected 0/4", stall_viol, rd_en_cnt);
    end
  endtask

  task automatic test_busy_clamp();
    bit ok;
    int bad;
    mem[40] = 32'hD0; mem[41] = 32'hD1;
    clear_mon();
    send(5'd3, 16'd2, 64'h0);
    @(negedge clk);
    tx_dest  = 5'd17;
    tx_len   = 16'd7;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_done(1, 100, ok);
    repeat (5) @(negedge clk);
    checks++;
    if (!ok || flit_q.size() != 4 || done_cnt != 1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore: got flits=%0d dones=%0d busy=%b, expected 4/1/0", flit_q.size(), done_cnt, tx_busy);
    end else begin
      checks++;
      if (flit_q[3] !== 34'h2_0000_00D1) begin
        errors++;
        $display("FAIL busy_last: got %h, expected 2000000d1", flit_q[3]);
      end
    end
    for (int i = 0; i < 1024; i++) mem[40 + i] = 32'h5A00_0000 + 32'(i);
    mem[1064] = 32'hFFFF_FFFF;
    clear_mon();
    send(5'd1, 16'd2000, 64'h55);
    wait_done(1, 4000, ok);
    checks++;
    if (!ok || flit_q.size() != 1026) begin
      errors++;
      $display("FAIL clamp_count: got %0d flits done=%0d, expected 1026 flits 1 done", flit_q.size(), done_cnt);
    end else begin
      bad = 0;
      for (int i = 0; i < 1024; i++) begin
        if (flit_q[i + 2][31:0] !== 32'h5A00_0000 + 32'(i)) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL clamp_data: got %0d wrong payload words, expected 0", bad);
      end
      checks++;
      if (flit_q[1024] !== 34'h0_5A00_03FE || flit_q[1025] !== 34'h2_5A00_03FF) begin
        errors++;
        $display("FAIL clamp_tail: got %h %h, expected 05a0003fe 25a0003ff", flit_q[1024], flit_q[1025]);
      end
    end
    checks++;
    if (rd_en_cnt != 1024 || last_addr !== 12'd1063) begin
      errors++;
      $display("FAIL clamp_reads: got reads=%0d last_addr=%0d, expected 1024/1063", rd_en_cnt, last_addr);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    for (int i = 0; i < 4; i++) mem[40 + i] = 32'hC0 + 32'(i);
    clear_mon();
    send(5'd2, 16'd4, 64'h77);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.valid[0] && bus.flit === 34'h0_0000_00C2) begin found = 1'b1; break; end
    end
    rst_source_n = 1'b0;
    @(negedge clk);
    checks++;
    if (!found || bus.valid !== 1'b0 || tx_busy !== 1'b0 || tx_count !== 32'd0 || tx_done !== 1'b0) begin
      errors++;
      $display("FAIL midrst: got found=%b valid=%b busy=%b count=%0d done=%b, expected 1/0/0/0/0",
               found, bus.valid, tx_busy, tx_count, tx_done);
    end
    rst_source_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (done_cnt != 0 || bus.valid !== 1'b0 || bus.mem_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after: got dones=%0d valid=%b rd_en=%b, expected 0/0/0", done_cnt, bus.valid, bus.mem_rd_en);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    mem[40] = 32'hE0;
    clear_mon();
    for (int p = 0; p < 5; p++) begin
      send(5'(p), 16'd1, 64'(p));
      wait_done(p + 1, 50, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL b2b_timeout%0d: got dones=%0d, expected %0d", p, done_cnt, p + 1);
      end
    end
    checks++;
    if (tx_count !== 32'd5 || done_cnt != 5 || done_wide != 0 || flit_q.size() != 15) begin
      errors++;
      $display("FAIL b2b_status: got count=%0d dones=%0d wide=%0d flits=%0d, expected 5/5/0/15",
               tx_count, done_cnt, done_wide, flit_q.size());
    end
  endtask

  initial begin
    rst_source_n    = 1'b0;
    tx_start        = 1'b0;
    tx_dest         = 5'd0;
    tx_len          = 16'd0;
    GTB             = 64'd0;
    bus.ready       = 1'b1;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h5500_0000 | 32'(i);
    test_reset();
    test_basic();
    test_zero_len();
    test_backpressure();
    test_busy_clamp();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
